// File: rtl/booth_r4_mul.sv
// Radix-4 modified-Booth sequential multiplier with start/busy/done handshake.
// Ports: clk, reset (sync, active-low), start, signed_mode, inM, inQ -> busy, done, product.
module booth_r4_mul #(
    parameter int WIDTH = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     inM,
    input  logic [WIDTH-1:0]     inQ,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    // Extended width is always even so the multiplier splits into 2-bit digits,
    // and has at least one spare top bit so unsigned operands recode as positive.
    localparam int EW    = (WIDTH % 2 == 0) ? WIDTH + 2 : WIDTH + 1;
    localparam int NITER = EW / 2;
    localparam int CNT_W = $clog2(NITER + 1);
    localparam int AW    = EW + 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [AW-1:0]        a_q, a_d;
    logic [EW-1:0]        q_q, q_d;
    logic [EW-1:0]        m_q, m_d;
    logic                 qm1_q, qm1_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic                 done_q, done_d;

    logic [EW-1:0]        ext_m;
    logic [EW-1:0]        ext_q;
    logic [AW-1:0]        m_x;
    logic [AW-1:0]        base;
    logic [AW-1:0]        addend;
    logic [AW-1:0]        sum;
    logic [AW-1:0]        a_shift;
    logic [EW-1:0]        q_shift;
    logic                 sel_zero;
    logic                 sel_two;
    logic                 sel_neg;

    always_comb begin
        ext_m = signed_mode ? {{(EW-WIDTH){inM[WIDTH-1]}}, inM}
                            : {{(EW-WIDTH){1'b0}}, inM};
        ext_q = signed_mode ? {{(EW-WIDTH){inQ[WIDTH-1]}}, inQ}
                            : {{(EW-WIDTH){1'b0}}, inQ};
    end

    // Booth digit recode from {Q[1],Q[0],q_m1}.
    always_comb begin
        sel_zero = 1'b0;
        sel_two  = 1'b0;
        sel_neg  = 1'b0;
        unique case ({q_q[1:0], qm1_q})
            3'b000, 3'b111: sel_zero = 1'b1;
            3'b001, 3'b010: ;
            3'b011:         sel_two  = 1'b1;
            3'b100: begin
                sel_two = 1'b1;
                sel_neg = 1'b1;
            end
            3'b101, 3'b110: sel_neg  = 1'b1;
            default:        sel_zero = 1'b1;
        endcase
    end

    // Subtraction reuses the adder: invert the addend and inject a carry.
    always_comb begin
        m_x     = {{2{m_q[EW-1]}}, m_q};
        base    = sel_two ? {m_x[AW-2:0], 1'b0} : m_x;
        if (sel_zero) begin
            base = '0;
        end
        addend  = sel_neg ? ~base : base;
        sum     = a_q + addend + AW'(sel_neg);
        a_shift = {{2{sum[AW-1]}}, sum[AW-1:2]};
        q_shift = {sum[1:0], q_q[EW-1:2]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        m_d     = m_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        done_d  = 1'b0;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    m_d     = ext_m;
                    q_d     = ext_q;
                    a_d     = '0;
                    qm1_d   = 1'b0;
                    cnt_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = a_shift;
                q_d   = q_shift;
                qm1_d = q_q[1];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(NITER - 1)) begin
                    prod_d  = {a_shift[2*WIDTH-EW-1:0], q_shift};
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            m_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            prod_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            m_q     <= m_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            done_q  <= done_d;
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign done    = done_q;
    assign product = prod_q;

endmodule

// File: tb/tb_booth_r4_mul.sv
// Directed bench for booth_r4_mul: 24-bit vectors, handshake, reset,
// and strided signed/unsigned sweeps of 7- and 8-bit instances.
module tb_booth_r4_mul;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;

    logic        st24, sm24, busy24, done24;
    logic [23:0] m24, q24;
    logic [47:0] p24;

    logic        st7, sm7, busy7, done7;
    logic [6:0]  m7, q7;
    logic [13:0] p7;

    logic        st8, sm8, busy8, done8;
    logic [7:0]  m8, q8;
    logic [15:0] p8;

    booth_r4_mul #(.WIDTH(24)) dut24 (
        .clk(clk), .reset(reset), .start(st24), .signed_mode(sm24),
        .inM(m24), .inQ(q24), .busy(busy24), .done(done24), .product(p24)
    );

    booth_r4_mul #(.WIDTH(7)) dut7 (
        .clk(clk), .reset(reset), .start(st7), .signed_mode(sm7),
        .inM(m7), .inQ(q7), .busy(busy7), .done(done7), .product(p7)
    );

    booth_r4_mul #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(st8), .signed_mode(sm8),
        .inM(m8), .inQ(q8), .busy(busy8), .done(done8), .product(p8)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic sm, input longint a,
                                            input longint b, input int w);
        longint sa, sb;
        sa = a;
        sb = b;
        if (sm && a[w-1]) sa = a - (longint'(1) << w);
        if (sm && b[w-1]) sb = b - (longint'(1) << w);
        return 64'(sa * sb) & ((64'd1 << (2 * w)) - 64'd1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run24(input logic sm, input logic [23:0] a, input logic [23:0] b,
                         output int lat);
        sm24 = sm; m24 = a; q24 = b; st24 = 1'b1;
        tick();
        st24 = 1'b0;
        lat = 0;
        while (done24 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic vec24(input string tag, input logic sm, input logic [23:0] a,
                         input logic [23:0] b, input logic [47:0] exp);
        int lat;
        run24(sm, a, b, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd13);
        chk(tag, 64'(p24), 64'(exp));
    endtask

    task automatic run7(input logic sm, input logic [6:0] a, input logic [6:0] b,
                        output int lat);
        sm7 = sm; m7 = a; q7 = b; st7 = 1'b1;
        tick();
        st7 = 1'b0;
        lat = 0;
        while (done7 !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("w7_done", 64'(done7), 64'd1);
        chk("w7_prod", 64'(p7), ref_mul(sm, longint'(a), longint'(b), 7));
    endtask

    task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        sm8 = sm; m8 = a; q8 = b; st8 = 1'b1;
        tick();
        st8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 50) begin
            tick();
            lat++;
        end
        chk("w8_done", 64'(done8), 64'd1);
        chk("w8_prod", 64'(p8), ref_mul(sm, longint'(a), longint'(b), 8));
    endtask

    initial begin
        int lat;
        int lat2;
        logic [6:0] c7 [4];
        logic [7:0] c8 [4];

        reset = 1'b0;
        st24 = 1'b0; sm24 = 1'b0; m24 = '0; q24 = '0;
        st7 = 1'b0; sm7 = 1'b0; m7 = '0; q7 = '0;
        st8 = 1'b0; sm8 = 1'b0; m8 = '0; q8 = '0;
        tick();
        tick();
        chk("rst_busy", 64'(busy24), 64'd0);
        chk("rst_done", 64'(done24), 64'd0);
        chk("rst_prod", 64'(p24), 64'd0);
        reset = 1'b1;
        tick();

        // Unsigned max*max, with latency and DONE->IDLE behaviour.
        run24(1'b0, 24'hFFFFFF, 24'hFFFFFF, lat);
        chk("umax_lat", 64'(lat), 64'd13);
        chk("umax_prod", 64'(p24), 64'hFFFFFE000001);
        chk("done_busy", 64'(busy24), 64'd1);
        tick();
        chk("idle_busy", 64'(busy24), 64'd0);
        chk("idle_done", 64'(done24), 64'd0);
        chk("idle_hold", 64'(p24), 64'hFFFFFE000001);

        vec24("s_m1x1", 1'b1, 24'hFFFFFF, 24'h000001, 48'hFFFFFFFFFFFF);
        vec24("s_min2", 1'b1, 24'h800000, 24'h800000, 48'h400000000000);
        vec24("zero", 1'b0, 24'h000000, 24'h123456, 48'h000000000000);
        vec24("ident", 1'b0, 24'h000001, 24'hABCDEF, 48'h000000ABCDEF);
        vec24("s_3xm2", 1'b1, 24'h000003, 24'hFFFFFE, 48'hFFFFFFFFFFFA);
        vec24("u_big2", 1'b0, 24'h800000, 24'h000002, 48'h000001000000);
        vec24("s_m1m1", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001);
        tick();

        // Start pulsed during RUN with new operands must be ignored.
        sm24 = 1'b0; m24 = 24'h000123; q24 = 24'h000456; st24 = 1'b1;
        tick();
        st24 = 1'b0;
        tick();
        tick();
        tick();
        sm24 = 1'b1; m24 = 24'hFFFFFF; q24 = 24'hFFFFFF; st24 = 1'b1;
        tick();
        st24 = 1'b0;
        lat = 4;
        while (done24 !== 1'b1 && lat < 200) begin
            tick();
            lat++;
        end
        chk("ign_lat", 64'(lat), 64'd13);
        chk("ign_prod", 64'(p24), 64'h00000004EDC2);
        tick();
        chk("ign_idle", 64'(busy24), 64'd0);

        // Back-to-back: start held while DONE is high.
        run24(1'b0, 24'h000010, 24'h000010, lat);
        chk("b2b_p1", 64'(p24), 64'h000000000100);
        sm24 = 1'b0; m24 = 24'h000002; q24 = 24'h000003; st24 = 1'b1;
        tick();
        st24 = 1'b0;
        chk("b2b_busy", 64'(busy24), 64'd1);
        chk("b2b_ndone", 64'(done24), 64'd0);
        chk("b2b_hold", 64'(p24), 64'h000000000100);
        lat2 = 1;
        while (done24 !== 1'b1 && lat2 < 200) begin
            tick();
            lat2++;
        end
        chk("b2b_gap", 64'(lat2), 64'd14);
        chk("b2b_p2", 64'(p24), 64'h000000000006);
        tick();

        // Reset at RUN count 5 discards the operation and clears product.
        sm24 = 1'b0; m24 = 24'hFFFFFF; q24 = 24'hFFFFFF; st24 = 1'b1;
        tick();
        st24 = 1'b0;
        repeat (5) tick();
        reset = 1'b0;
        tick();
        chk("mid_busy", 64'(busy24), 64'd0);
        chk("mid_done", 64'(done24), 64'd0);
        chk("mid_prod", 64'(p24), 64'd0);
        reset = 1'b1;
        tick();
        vec24("post_rst", 1'b1, 24'hFFFFFF, 24'hFFFFFF, 48'h000000000001);
        tick();

        // Small widths: latency, corner pairs, then strided sweeps.
        run7(1'b0, 7'd5, 7'd9, lat);
        chk("w7_lat", 64'(lat), 64'd4);
        run8(1'b0, 8'd5, 8'd9, lat);
        chk("w8_lat", 64'(lat), 64'd5);

        c7[0] = 7'h00; c7[1] = 7'h01; c7[2] = 7'h7F; c7[3] = 7'h40;
        c8[0] = 8'h00; c8[1] = 8'h01; c8[2] = 8'hFF; c8[3] = 8'h80;
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 4; i++) begin
                for (int j = 0; j < 4; j++) begin
                    run7(s[0], c7[i], c7[j], lat);
                    run8(s[0], c8[i], c8[j], lat);
                end
            end
        end

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 128; i += 3) begin
                for (int j = 0; j < 128; j += 5) begin
                    run7(s[0], 7'(i), 7'(j), lat);
                end
            end
        end

        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < 256; i += 7) begin
                for (int j = 0; j < 256; j += 9) begin
                    run8(s[0], 8'(i), 8'(j), lat);
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
